// File: rtl/gpr_write_mux.sv
// -----------------------------------------------------------------------------
// gpr_write_mux
//
// Write-back source selector for the general-purpose register file. Chooses
// the GPR write data from the ALU result, the memory load data or the
// return-address value produced by the PC path. The choice is purely
// combinational. A registered copy of the data and an error flag are also
// provided for pipelined write-back and debug.
//
// Ports (declaration order is fixed so that older positional instantiations
// that connect only the first five ports keep working):
//   alu        in   WIDTH  ALU result
//   memory     in   WIDTH  memory load data
//   pc         in   WIDTH  return address, already offset, passed unmodified
//   sel        in   2      write-back source code (GPR_WRITE_*)
//   out        out  WIDTH  selected write data, combinational
//   clk        in   1      rising-edge clock, registered copy only
//   rst        in   1      asynchronous active-high reset of registered copy
//   out_q      out  WIDTH  out registered on rising clk
//   sel_err    out  1      high when sel is the reserved code (or X/Z)
//   sel_err_q  out  1      sel_err registered on rising clk
// -----------------------------------------------------------------------------
module gpr_write_mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] alu,
  input  logic [WIDTH-1:0] memory,
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_err,
  output logic             sel_err_q
);

  // Write-back source codes, matching the control unit's GPR_WRITE_* codes.
  localparam logic [1:0] GPR_WRITE_ALU = 2'b00;
  localparam logic [1:0] GPR_WRITE_MEM = 2'b01;
  localparam logic [1:0] GPR_WRITE_PC  = 2'b10;

  // Combinational selection. The reserved code 2'b11 and any X/Z on sel
  // both fall into the default arm: in simulation an unknown sel matches
  // none of the explicit codes, so it yields zero data and a raised error
  // flag instead of propagating X into the register file.
  always_comb begin
    // NOTE: every output gets a value before the case so no path through
    // the block leaves it unassigned; otherwise a latch would be inferred.
    out     = '0;
    sel_err = 1'b0;
    case (sel)
      GPR_WRITE_ALU: out = alu;
      GPR_WRITE_MEM: out = memory;
      GPR_WRITE_PC:  out = pc;
      default: begin
        out     = '0;
        sel_err = 1'b1;
      end
    endcase
  end

  // Registered copy for pipelined write-back. Reset clears it immediately,
  // independent of the clock; the first edge after release captures the
  // current combinational values.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    if (rst) begin
      out_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      out_q     <= out;
      sel_err_q <= sel_err;
    end
  end

endmodule

// File: tb/tb_gpr_write_mux.sv
// -----------------------------------------------------------------------------
// tb_gpr_write_mux
//
// Self-checking bench for gpr_write_mux. A table of combinational vectors is
// applied with no clock running, followed by hand-written sequences for the
// registered path and asynchronous reset. A second instance is connected
// positionally to confirm the port order.
// -----------------------------------------------------------------------------
module tb_gpr_write_mux;

  localparam int WIDTH = 32;

  logic [WIDTH-1:0] alu, memory, pc;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out, out_q;
  logic             sel_err, sel_err_q;
  logic             clk, rst, clk_run;

  logic [WIDTH-1:0] out_p, out_q_p;
  logic             sel_err_p, sel_err_q_p;

  gpr_write_mux #(.WIDTH(WIDTH)) dut (
    .alu       (alu),
    .memory    (memory),
    .pc        (pc),
    .sel       (sel),
    .out       (out),
    .clk       (clk),
    .rst       (rst),
    .out_q     (out_q),
    .sel_err   (sel_err),
    .sel_err_q (sel_err_q)
  );

  // Positional hookup in the fixed declaration order.
  gpr_write_mux #(WIDTH) dut_pos (alu, memory, pc, sel, out_p, clk, rst,
                                  out_q_p, sel_err_p, sel_err_q_p);

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    string            name;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] memory;
    logic [WIDTH-1:0] pc;
    logic [1:0]       sel;
    logic [WIDTH-1:0] exp_out;
    logic             exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic next_edge();
    // Drive on the falling edge, sample #1 after the following rising edge.
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"sel_alu",      32'h00C0FFEE, 32'hBAADC0DE, 32'hDEADBEEF, 2'b00, 32'h00C0FFEE, 1'b0};
    vecs[1] = '{"sel_mem",      32'h00C0FFEE, 32'hBAADC0DE, 32'hDEADBEEF, 2'b01, 32'hBAADC0DE, 1'b0};
    vecs[2] = '{"sel_pc",       32'h00C0FFEE, 32'hBAADC0DE, 32'hDEADBEEF, 2'b10, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{"sel_reserved", 32'h00C0FFEE, 32'hBAADC0DE, 32'hDEADBEEF, 2'b11, 32'h00000000, 1'b1};
    vecs[4] = '{"back_to_alu",  32'h00C0FFEE, 32'hBAADC0DE, 32'hDEADBEEF, 2'b00, 32'h00C0FFEE, 1'b0};
    vecs[5] = '{"pc_change",    32'h00C0FFEE, 32'hBAADC0DE, 32'h00400008, 2'b10, 32'h00400008, 1'b0};
    vecs[6] = '{"all_ones_mem", 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 2'b01, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{"simul_change", 32'h80000001, 32'h12345678, 32'h7FFFFFFE, 2'b00, 32'h80000001, 1'b0};

    clk_run = 1'b0;
    rst     = 1'b1;
    alu     = '0;
    memory  = '0;
    pc      = '0;
    sel     = 2'b00;
    #1;
    check("reset_out_q",     out_q,     32'h0);
    check("reset_sel_err_q", {31'b0, sel_err_q}, 32'h0);

    // Combinational vectors, no clock running.
    for (int i = 0; i < 8; i++) begin
      alu    = vecs[i].alu;
      memory = vecs[i].memory;
      pc     = vecs[i].pc;
      sel    = vecs[i].sel;
      #1;
      check({vecs[i].name, "_out"},     out,                 vecs[i].exp_out);
      check({vecs[i].name, "_err"},     {31'b0, sel_err},    {31'b0, vecs[i].exp_err});
      check({vecs[i].name, "_pos_out"}, out_p,               vecs[i].exp_out);
    end
    check("no_clk_out_q", out_q, 32'h0);

    // Registered path.
    alu    = 32'h00C0FFEE;
    memory = 32'hBAADC0DE;
    pc     = 32'hDEADBEEF;
    sel    = 2'b01;
    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    check("held_in_reset", out_q, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    next_edge();
    check("first_edge_mem", out_q, 32'hBAADC0DE);
    check("first_edge_err", {31'b0, sel_err_q}, 32'h0);
    // Combinational output is independent of rst.
    check("comb_after_rel", out, 32'hBAADC0DE);

    @(negedge clk);
    sel = 2'b11;
    #1;
    check("not_yet_err_q", {31'b0, sel_err_q}, 32'h0);
    next_edge();
    check("reserved_err_q", {31'b0, sel_err_q}, 32'h1);
    check("reserved_out_q", out_q, 32'h0);

    @(negedge clk);
    sel = 2'b10;
    next_edge();
    check("pc_out_q",  out_q, 32'hDEADBEEF);
    check("pc_err_q",  {31'b0, sel_err_q}, 32'h0);

    // Mid-cycle asynchronous reset while error flag is set.
    @(negedge clk);
    sel = 2'b11;
    next_edge();
    check("pre_rst_err_q", {31'b0, sel_err_q}, 32'h1);
    #2;
    sel = 2'b00;
    rst = 1'b1;
    #1;
    check("async_rst_out_q", out_q, 32'h0);
    check("async_rst_err_q", {31'b0, sel_err_q}, 32'h0);
    check("comb_in_rst",     out,   32'h00C0FFEE);
    repeat (2) @(posedge clk);
    #1;
    check("stay_rst_out_q", out_q, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    next_edge();
    check("rel_alu_out_q", out_q, 32'h00C0FFEE);
    check("pos_out_q",     out_q_p, 32'h00C0FFEE);

    clk_run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_write_mux.md
# gpr_write_mux

Write-back source selector for the MIPS CPU's general-purpose register file. It picks the GPR write data from three sources: the ALU result, the memory load data, or the return-address value from the PC path. The select comes from the control unit's `GPR_WRITE_*` code. The selection is purely combinational, and a registered copy with an error flag is provided for pipelined write-back and debug.

## Interface
Parameters:
- WIDTH, 32, data width of all sources and outputs.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  clock, rising-edge, used only by the registered copy.
- rst  input  1  asynchronous active-high reset of the registered outputs.
- alu  input  WIDTH  ALU result.
- memory  input  WIDTH  memory load data.
- pc  input  WIDTH  return address, already offset by the PC logic; passed through unmodified.
- sel  input  2  write-back source code from `defines.v`.
- out  output  WIDTH  selected write data, combinational.
- out_q  output  WIDTH  `out` registered on rising clk.
- sel_err  output  1  combinational flag, high when `sel` is the reserved code.
- sel_err_q  output  1  `sel_err` registered on rising clk.

Declaration order is fixed: alu, memory, pc, sel, out, clk, rst, out_q, sel_err, sel_err_q. Existing positional instantiations connect only the first five ports and must keep working with the trailing ports unconnected.

## Operation
Select codes, defined in `defines.v`:
- `GPR_WRITE_ALU` = 2'b00: out = alu.
- `GPR_WRITE_MEM` = 2'b01: out = memory.
- `GPR_WRITE_PC` = 2'b10: out = pc.
- 2'b11 is reserved: out = 0 and sel_err = 1.

Rules:
- No arithmetic, sign/zero extension or truncation; all paths are bit-exact WIDTH copies.
- X or Z on `sel`: out is driven to 0 and sel_err = 1. Simulation-only concern; synthesis treats this like the reserved code.
- out and sel_err are functions of the current inputs only; they do not depend on clk or rst.
- Registered path on each rising clk edge with rst low: out_q <= out, sel_err_q <= sel_err.

## Timing
- out and sel_err settle in zero cycles, within one delta or a combinational delay after any input change. There is no clock dependency, so a bench may check them after #1 with no clock running.
- out_q and sel_err_q have 1-cycle latency relative to the input sampled at the rising edge.
- rst asserted, at any time including mid-operation, forces out_q = 0 and sel_err_q = 0 immediately. Both stay 0 while rst is high.
- The first rising edge after rst deasserts captures the current out and sel_err.
- The combinational out is unaffected by rst.
- Reset values: out_q = 0, sel_err_q = 0. out and sel_err have no reset value; they always track their inputs.
- Simultaneous changes of sel and a source: out reflects the new sel applied to the new source values.

## Test plan
- alu=0x00C0FFEE, memory=0xBAADC0DE, pc=0xDEADBEEF, sel=00, wait #1 -> out=0x00C0FFEE, sel_err=0.
- Same sources, sel=01, wait #1 -> out=0xBAADC0DE. Then sel=10, wait #1 -> out=0xDEADBEEF. sel_err=0 throughout.
- sel=11 -> out=0x00000000, sel_err=1. Return to sel=00 -> out=0x00C0FFEE, sel_err=0.
- Hold sel=10 and change pc to 0x00400008 -> out=0x00400008 with no clock edge.
- Clock running, rst=1 -> out_q=0 and sel_err_q=0 asynchronously. Release rst with sel=01 -> the next rising edge gives out_q=0xBAADC0DE. Then sel=11 -> one edge later sel_err_q=1 and out_q=0.
- Positional instantiation with only (alu, memory, pc, sel, out) connected, running the first test above -> elaborates and out matches.
